rtc_alarm: RTL and testbench
============================

Name: rtc_alarm

Overview:
- Alarm stage directly downstream of the real-time-clock counter.
- Consumes the live hrs/mins/sec time value and holds a programmable alarm time (HH:MM), loaded through a valid/ready handshake.
- Raises a ring output when the time matches, and supports stop, snooze (bounded count) and auto-timeout.
- All logic is synchronous to clk60ns; the time inputs are treated as stable between clk60ns edges.

Parameters:
RING_SECS, 60, seconds a ring lasts before auto-stop (1..63)
SNOOZE_MINS, 5, minutes added to the current time on snooze (1..59)
MAX_SNOOZE, 3, snoozes allowed per alarm event; further snooze requests act as stop

Ports:
clk60ns  in  1  system clock
reset  in  1  synchronous, active-high reset
hrs  in  5  current hours, 0..23
mins  in  6  current minutes, 0..59
sec  in  6  current seconds, 0..59
alarm_en  in  1  level; 0 forces IDLE and silences ring
set_valid  in  1  alarm-time load request
set_hrs  in  5  requested alarm hours
set_mins  in  6  requested alarm minutes
set_ready  out  1  load can be accepted this cycle
set_err  out  1  one-cycle pulse, out-of-range load rejected
stop  in  1  level/pulse, silences ring
snooze  in  1  level/pulse, requests snooze
ring  out  1  alarm sounding
snoozing  out  1  high in SNOOZE state
alarm_hrs  out  5  programmed alarm hours
alarm_mins  out  6  programmed alarm minutes

Behaviour:
- Reset (synchronous, active-high; clock clk60ns):
  - state=IDLE; alarm_hrs=0, alarm_mins=0; target=00:00; snooze_cnt=0; ring_cnt=0.
  - ring=0, snoozing=0, set_err=0, set_ready=1; sec_q=0.
  - Reset mid-ring silences ring on the next edge.
- Second tick: sec_q registers sec every cycle; tick = (sec != sec_q). One tick per seconds change, regardless of how many clk60ns cycles the value is held.
- Match: tick && sec==0 && hrs==target_h && mins==target_m. Fires once per matching minute.
- Load handshake:
  - set_ready = (state != RINGING).
  - Accept on set_valid && set_ready.
  - If set_hrs>23 or set_mins>59: set_err=1 for one cycle; alarm_* and target unchanged.
  - Otherwise alarm_* and target take the new value on the next edge, and snooze_cnt=0.
  - An accept in SNOOZE returns to ARMED (or IDLE if alarm_en=0).
- States:
  - IDLE: ring=0. When alarm_en=1, go to ARMED next cycle.
  - ARMED: on match, go to RINGING; ring=1 from the next cycle; ring_cnt=0.
  - RINGING: ring=1; ring_cnt increments on each tick.
    - stop -> ARMED; target=alarm_*; snooze_cnt=0.
    - snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE; target=(hrs:mins)+SNOOZE_MINS; snooze_cnt+1.
    - snooze with snooze_cnt==MAX_SNOOZE is treated as stop.
    - ring_cnt==RING_SECS-1 on a tick -> ARMED (auto-stop, same as stop).
  - SNOOZE: snoozing=1, ring=0. On match -> RINGING.
- Priority within RINGING (same cycle): alarm_en=0 > stop > snooze > timeout.
- alarm_en=0 in any state -> IDLE next cycle; ring=0; target=alarm_*; snooze_cnt=0. alarm_* is retained.
- Snooze arithmetic:
  - m = mins + SNOOZE_MINS, computed 7 bits wide.
  - If m>59: m -= 60 and h = hrs+1, with h wrapping 23 -> 0.
  - Example: 23:58 + 5 = 00:03.
- A match coinciding with a load cycle uses the pre-load target.
- stop/snooze outside RINGING are ignored.
- Outputs are registered; ring latency from the matching tick is exactly 1 clk60ns cycle.

Test Plan:
1. Reset, alarm_en=1, load 07:30 (valid with ready); drive time 07:29:59 -> 07:30:00 -> ring=1 one cycle after the sec=0 cycle; alarm_hrs=7, alarm_mins=30.
2. Load hrs=24 mins=10 -> set_err pulses one cycle; alarm_* stays 07:30. Load 07:60 -> same. set_ready=0 while RINGING; a held set_valid is accepted only after stop.
3. Ring at 23:58:00 then snooze -> snoozing=1, ring=0; time 00:03:00 -> ring=1 again. Repeat three snoozes; the 4th snooze acts as stop: state ARMED, ring=0, target back to alarm time.
4. Ring with no action, sec advancing 1/s -> ring drops after exactly RING_SECS (60) ticks; the next day at the same time it rings again.
5. Assert stop and snooze in the same cycle while RINGING -> ARMED, snooze_cnt=0, snoozing=0. Deassert alarm_en during RINGING -> ring=0 next cycle, state IDLE.
6. Hold hrs/mins/sec at a matching value for 100 clk60ns cycles -> exactly one ring event. Assert reset mid-ring -> ring=0, alarm time 00:00 on the next edge.

Source files
------------

// File: rtl/rtc_alarm_if.sv
// Alarm-time load channel: valid/ready handshake plus one-cycle reject pulse.
interface rtc_alarm_if;
  logic       set_valid;
  logic [4:0] set_hrs;
  logic [5:0] set_mins;
  logic       set_ready;
  logic       set_err;

  modport master (output set_valid, set_hrs, set_mins, input  set_ready, set_err);
  modport slave  (input  set_valid, set_hrs, set_mins, output set_ready, set_err);
endinterface

// File: rtl/rtc_alarm.sv
// Alarm stage behind the RTC counter: programmable HH:MM alarm with ring,
// stop, bounded snooze and auto-timeout. Everything runs on clk60ns.
module rtc_alarm #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 5,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic        clk60ns,
  input  logic        reset,
  input  logic [4:0]  hrs,
  input  logic [5:0]  mins,
  input  logic [5:0]  sec,
  input  logic        alarm_en,
  rtc_alarm_if.slave  set_if,
  input  logic        stop,
  input  logic        snooze,
  output logic        ring,
  output logic        snoozing,
  output logic [4:0]  alarm_hrs,
  output logic [5:0]  alarm_mins
);
  localparam int SW = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      alm_h_q, alm_h_d, tgt_h_q, tgt_h_d;
  logic [5:0]      alm_m_q, alm_m_d, tgt_m_q, tgt_m_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [5:0]      rcnt_q, rcnt_d;
  logic [5:0]      sec_q;
  logic            err_q, err_d;

  logic            tick, match, accept, bad, load_ok;
  logic [6:0]      snz_m;
  logic [4:0]      snz_h;

  assign tick    = (sec != sec_q);
  assign match   = tick && (sec == 6'd0) && (hrs == tgt_h_q) && (mins == tgt_m_q);
  assign accept  = set_if.set_valid && set_if.set_ready;
  assign bad     = (set_if.set_hrs > 5'd23) || (set_if.set_mins > 6'd59);
  assign load_ok = accept && !bad;

  // Snooze target = now + SNOOZE_MINS, carrying into hours with a 23 -> 0 wrap.
  always_comb begin
    snz_m = {1'b0, mins} + 7'(SNOOZE_MINS);
    snz_h = hrs;
    if (snz_m > 7'd59) begin
      snz_m = snz_m - 7'd60;
      snz_h = (hrs >= 5'd23) ? 5'd0 : hrs + 5'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    alm_h_d = alm_h_q;
    alm_m_d = alm_m_q;
    tgt_h_d = tgt_h_q;
    tgt_m_d = tgt_m_q;
    scnt_d  = scnt_q;
    rcnt_d  = rcnt_q;
    err_d   = accept && bad;
    case (state_q)
      IDLE:    if (alarm_en) state_d = ARMED;
      ARMED:   if (match) begin
        state_d = RINGING;
        rcnt_d  = '0;
      end
      RINGING: begin
        if (tick) rcnt_d = rcnt_q + 6'd1;
        // Snooze past the limit degrades to a plain stop.
        if (stop || (snooze && scnt_q >= SW'(MAX_SNOOZE))
            || (!snooze && tick && rcnt_q == 6'(RING_SECS - 1))) begin
          state_d = ARMED;
          tgt_h_d = alm_h_q;
          tgt_m_d = alm_m_q;
          scnt_d  = '0;
        end else if (snooze) begin
          state_d = SNOOZE;
          tgt_h_d = snz_h;
          tgt_m_d = snz_m[5:0];
          scnt_d  = scnt_q + SW'(1);
        end
      end
      SNOOZE: begin
        if (match) begin
          state_d = RINGING;
          rcnt_d  = '0;
        end else if (load_ok) begin
          state_d = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_ok) begin
      alm_h_d = set_if.set_hrs;
      alm_m_d = set_if.set_mins;
      tgt_h_d = set_if.set_hrs;
      tgt_m_d = set_if.set_mins;
      scnt_d  = '0;
    end
    if (!alarm_en) begin
      state_d = IDLE;
      tgt_h_d = alm_h_d;
      tgt_m_d = alm_m_d;
      scnt_d  = '0;
    end
  end

  always_ff @(posedge clk60ns) begin
    if (reset) begin
      state_q <= IDLE;
      alm_h_q <= '0;
      alm_m_q <= '0;
      tgt_h_q <= '0;
      tgt_m_q <= '0;
      scnt_q  <= '0;
      rcnt_q  <= '0;
      sec_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alm_h_q <= alm_h_d;
      alm_m_q <= alm_m_d;
      tgt_h_q <= tgt_h_d;
      tgt_m_q <= tgt_m_d;
      scnt_q  <= scnt_d;
      rcnt_q  <= rcnt_d;
      sec_q   <= sec;
      err_q   <= err_d;
    end
  end

  assign ring             = (state_q == RINGING);
  assign snoozing         = (state_q == SNOOZE);
  assign set_if.set_ready = (state_q != RINGING);
  assign set_if.set_err   = err_q;
  assign alarm_hrs        = alm_h_q;
  assign alarm_mins       = alm_m_q;
endmodule

// File: tb/tb_rtc_alarm.sv
// Scoreboard bench for rtc_alarm: expectations queued with each stimulus cycle,
// drained and compared just after the following clk60ns edge.
module tb_rtc_alarm;
  logic       clk60ns = 1'b0;
  logic       reset, alarm_en, stop, snooze;
  logic [4:0] hrs;
  logic [5:0] mins, sec;
  logic       ring, snoozing;
  logic [4:0] alarm_hrs;
  logic [5:0] alarm_mins;

  rtc_alarm_if aif();

  rtc_alarm dut (
    .clk60ns(clk60ns), .reset(reset), .hrs(hrs), .mins(mins), .sec(sec),
    .alarm_en(alarm_en), .set_if(aif.slave), .stop(stop), .snooze(snooze),
    .ring(ring), .snoozing(snoozing), .alarm_hrs(alarm_hrs), .alarm_mins(alarm_mins)
  );

  always #30 clk60ns = ~clk60ns;

  localparam int S_RING = 0, S_SNZ = 1, S_ERR = 2, S_RDY = 3, S_AH = 4, S_AM = 5;

  typedef struct { string tag; int sel; int val; } exp_t;
  exp_t sbq[$];
  int   nvec = 0, nmis = 0;

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    nvec++;
    if (o !== e) begin
      nmis++;
      $display("FAIL %s: got %0d want %0d", tag, o, e);
    end
  endtask

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      S_RING:  return {7'd0, ring};
      S_SNZ:   return {7'd0, snoozing};
      S_ERR:   return {7'd0, aif.set_err};
      S_RDY:   return {7'd0, aif.set_ready};
      S_AH:    return {3'd0, alarm_hrs};
      default: return {2'd0, alarm_mins};
    endcase
  endfunction

  task automatic ex(input string tag, input int sel, input int v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    sbq.push_back(e);
  endtask

  task automatic ex_rs(input string tag, input int r, input int s);
    ex({tag, "_ring"}, S_RING, r);
    ex({tag, "_snz"},  S_SNZ,  s);
  endtask

  // Apply one cycle of time input, then check everything queued for it.
  task automatic cyc(input int h, input int m, input int s);
    exp_t e;
    logic [7:0] v;
    hrs = 5'(h); mins = 6'(m); sec = 6'(s);
    @(posedge clk60ns);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      v = e.val[7:0];
      chk(e.tag, obs(e.sel), v);
    end
  endtask

  task automatic load(input int h, input int m);
    aif.set_valid = 1'b1;
    aif.set_hrs   = 5'(h);
    aif.set_mins  = 6'(m);
  endtask

  initial begin
    #(60 * 60000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; alarm_en = 1'b0; stop = 1'b0; snooze = 1'b0;
    aif.set_valid = 1'b0; aif.set_hrs = '0; aif.set_mins = '0;
    hrs = '0; mins = '0; sec = '0;

    // 1: reset state, load 07:30, one-cycle ring latency
    ex_rs("rst", 0, 0); ex("rst_err", S_ERR, 0); ex("rst_rdy", S_RDY, 1);
    ex("rst_ah", S_AH, 0); ex("rst_am", S_AM, 0);
    cyc(7, 29, 59);
    reset = 1'b0; alarm_en = 1'b1;
    cyc(7, 29, 59);
    load(7, 30); ex("ld_ah", S_AH, 7); ex("ld_am", S_AM, 30); ex("ld_err", S_ERR, 0);
    cyc(7, 29, 59);
    aif.set_valid = 1'b0;
    ex_rs("pre", 0, 0); cyc(7, 29, 59);
    ex_rs("t1_ring", 1, 0); ex("t1_rdy", S_RDY, 0); cyc(7, 30, 0);

    // 2: held load blocked while ringing, then range rejects
    load(8, 15); ex("hold_rdy", S_RDY, 0); ex("hold_ah", S_AH, 7); ex_rs("hold", 1, 0);
    cyc(7, 30, 0);
    stop = 1'b1; ex_rs("stop", 0, 0); ex("stop_ah", S_AH, 7); cyc(7, 30, 0);
    stop = 1'b0; ex("acc_ah", S_AH, 8); ex("acc_am", S_AM, 15); cyc(7, 30, 0);
    load(7, 30); ex("rl_ah", S_AH, 7); ex("rl_am", S_AM, 30); cyc(7, 30, 0);
    load(24, 10); ex("e24_err", S_ERR, 1); ex("e24_ah", S_AH, 7); ex("e24_am", S_AM, 30);
    cyc(7, 30, 0);
    load(7, 60); ex("e60_err", S_ERR, 1); ex("e60_ah", S_AH, 7); ex("e60_am", S_AM, 30);
    cyc(7, 30, 0);
    aif.set_valid = 1'b0; ex("err_pulse", S_ERR, 0); cyc(7, 30, 0);

    // 3: ring at 23:58, snooze with midnight wrap, fourth snooze acts as stop
    load(23, 58); ex("l2358_ah", S_AH, 23); cyc(7, 30, 0);
    aif.set_valid = 1'b0;
    ex_rs("s0", 0, 0); cyc(23, 57, 59);
    ex_rs("s0r", 1, 0); cyc(23, 58, 0);
    snooze = 1'b1; ex_rs("snz1", 0, 1); cyc(23, 58, 0); snooze = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ex_rs("snzwait", 0, 1); cyc(0, 2 + 5 * k, 59);
      ex_rs("snzring", 1, 0); cyc(0, 3 + 5 * k, 0);
      snooze = 1'b1;
      if (k < 2) ex_rs("snzn", 0, 1);
      else       ex_rs("snz4stop", 0, 0);
      cyc(0, 3 + 5 * k, 0);
      snooze = 1'b0;
    end
    ex_rs("nosnz", 0, 0); cyc(0, 17, 59);
    ex_rs("nosnz_r", 0, 0); cyc(0, 18, 0);
    ex_rs("rest", 0, 0); cyc(23, 57, 59);
    ex_rs("rest_r", 1, 0); cyc(23, 58, 0);

    // 4: auto-timeout after RING_SECS ticks, each second held two cycles
    for (int s = 1; s < 60; s++) begin
      repeat (2) begin
        ex_rs("to_hold", 1, 0); cyc(23, 58, s);
      end
    end
    ex_rs("timeout", 0, 0); cyc(23, 59, 0);
    ex_rs("day2", 0, 0); cyc(23, 57, 59);
    ex_rs("day2_r", 1, 0); cyc(23, 58, 0);

    // 5: stop+snooze together, then alarm_en drop
    stop = 1'b1; snooze = 1'b1; ex_rs("stpsnz", 0, 0); cyc(23, 58, 0);
    stop = 1'b0; snooze = 1'b0;
    ex_rs("re", 0, 0); cyc(23, 57, 59);
    ex_rs("re_r", 1, 0); cyc(23, 58, 0);
    alarm_en = 1'b0; ex_rs("en0", 0, 0); ex("en0_ah", S_AH, 23); ex("en0_am", S_AM, 58);
    cyc(23, 58, 0);
    ex_rs("idle", 0, 0); cyc(23, 57, 59);
    ex_rs("idle_r", 0, 0); cyc(23, 58, 0);
    alarm_en = 1'b1; cyc(23, 58, 0);

    // 6: matching time held 100 cycles gives one ring event; reset mid-ring
    ex_rs("h0", 0, 0); cyc(23, 57, 59);
    for (int i = 0; i < 100; i++) begin
      stop = (i == 1);
      ex_rs("held", (i == 0) ? 1 : 0, 0);
      cyc(23, 58, 0);
    end
    stop = 1'b0;
    ex_rs("rr", 0, 0); cyc(23, 57, 59);
    ex_rs("rr_r", 1, 0); cyc(23, 58, 0);
    reset = 1'b1;
    ex_rs("mrst", 0, 0); ex("mrst_ah", S_AH, 0); ex("mrst_am", S_AM, 0);
    ex("mrst_rdy", S_RDY, 1);
    cyc(23, 58, 0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
